// File: rtl/counter_pkg.sv
// Shared definitions for the multimode counter: mode encoding and the
// one-shot sequencer state type.
package counter_pkg;

  // Counting modes as presented on the mode input.
  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_ONESHOT  = 2'b11
  } mode_t;

  // One-shot down-count sequencer states.
  typedef enum logic [1:0] {
    OS_IDLE = 2'b00,
    OS_RUN  = 2'b01,
    OS_DONE = 2'b10
  } os_state_t;

  // Direction a mode starts in after ld/clear: 1 = down.
  function automatic logic mode_counts_down(input mode_t m);
    return (m == MODE_DOWN) || (m == MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/ctr_step.sv
// Combinational single-step evaluator: given the present count, limit,
// direction, wrap setting and mode, produce the count and direction after
// one enabled step and flag whether the step hit a boundary.
module ctr_step
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  input  logic             wrap,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_count,
  output logic             next_dir,
  output logic             hit
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mode_t            mode_e;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] dec_clamped;

  assign mode_e      = mode_t'(mode);
  assign inc         = count + ONE;
  assign dec         = count - ONE;
  assign dec_clamped = (dec > limit) ? limit : dec;

  // Next count / direction / boundary for one enabled step in each mode.
  always_comb begin
    next_count = count;
    next_dir   = dir;
    hit        = 1'b0;
    case (mode_e)
      MODE_UP: begin
        next_dir = 1'b0;
        if (count >= limit) begin
          hit        = 1'b1;
          next_count = wrap ? '0 : limit;
        end else begin
          next_count = inc;
        end
      end
      MODE_DOWN: begin
        next_dir = 1'b1;
        if (count == '0) begin
          hit        = 1'b1;
          next_count = wrap ? limit : '0;
        end else if (count > limit) begin
          next_count = limit;
        end else begin
          next_count = dec;
        end
      end
      MODE_PINGPONG: begin
        if (!dir) begin
          if (count >= limit) begin
            hit        = 1'b1;
            next_dir   = 1'b1;
            next_count = (limit == '0) ? '0 : (limit - ONE);
          end else begin
            next_count = inc;
          end
        end else begin
          if (count == '0) begin
            hit        = 1'b1;
            next_dir   = 1'b0;
            next_count = (limit == '0) ? '0 : ONE;
          end else begin
            next_count = dec_clamped;
          end
        end
      end
      MODE_ONESHOT: begin
        next_dir = 1'b1;
        if (count == '0) begin
          hit        = 1'b1;
          next_count = '0;
        end else begin
          next_count = dec;
        end
      end
      default: begin
        next_count = count;
      end
    endcase
  end

endmodule

// File: rtl/multimode_counter.sv
// Multimode counter: up, down, ping-pong and one-shot down counting within
// 0..limit, with synchronous load/clear, terminal-count pulse, sticky
// boundary flag and a one-shot sequencer. All outputs come from flops.
module multimode_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             ld,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] limit,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             wrap,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             ovf,
  output logic             done
);

  mode_t            mode_e;
  os_state_t        state_q;
  os_state_t        state_d;
  logic [WIDTH-1:0] count_d;
  logic             dir_d;
  logic             tc_d;
  logic             ovf_d;
  logic             done_d;
  logic [WIDTH-1:0] step_count;
  logic             step_dir;
  logic             step_hit;

  assign mode_e = mode_t'(mode);

  ctr_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .count     (count),
    .limit     (limit),
    .dir       (dir),
    .wrap      (wrap),
    .mode      (mode),
    .next_count(step_count),
    .next_dir  (step_dir),
    .hit       (step_hit)
  );

  // Next-state and next-output selection: ld > clear > enabled step > hold.
  always_comb begin
    count_d = count;
    dir_d   = dir;
    ovf_d   = ovf;
    tc_d    = 1'b0;
    state_d = state_q;
    if (ld) begin
      count_d = count_in;
      ovf_d   = 1'b0;
      dir_d   = mode_counts_down(mode_e);
      state_d = (mode_e == MODE_ONESHOT) ? OS_RUN : OS_IDLE;
    end else if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
      dir_d   = mode_counts_down(mode_e);
      state_d = OS_IDLE;
    end else if (mode_e != MODE_ONESHOT) begin
      // Parking the sequencer in IDLE whenever another mode is selected is
      // equivalent to forcing IDLE on the edge of a mode change, since only
      // ld can leave IDLE once one-shot is selected again.
      state_d = OS_IDLE;
      if (en) begin
        count_d = step_count;
        dir_d   = step_dir;
        tc_d    = step_hit;
        if (step_hit && (mode_e != MODE_PINGPONG)) begin
          ovf_d = 1'b1;
        end
      end
    end else if (en) begin
      dir_d = 1'b1;
      case (state_q)
        OS_RUN: begin
          count_d = step_count;
          tc_d    = step_hit;
          if (step_hit) begin
            state_d = OS_DONE;
          end
        end
        OS_DONE: begin
          count_d = '0;
        end
        default: begin
          count_d = count;
        end
      endcase
    end
    done_d = (state_d == OS_DONE);
  end

  // One-shot sequencer state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      dir   <= 1'b0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      count <= count_d;
      dir   <= dir_d;
      tc    <= tc_d;
      ovf   <= ovf_d;
      done  <= done_d;
    end
  end

endmodule

// File: tb/tb_multimode_counter.sv
// Scoreboard bench for multimode_counter: directed sequences followed by
// randomized stimulus, checked against a behavioural model.
module tb_multimode_counter;

  localparam int WIDTH = 8;
  localparam int MAXV  = 255;

  logic             clock;
  logic             reset_n;
  logic             clear;
  logic             ld;
  logic [WIDTH-1:0] count_in;
  logic [WIDTH-1:0] limit;
  logic             en;
  logic [1:0]       mode;
  logic             wrap;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             tc;
  logic             ovf;
  logic             done;

  multimode_counter #(
    .WIDTH(WIDTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .ld      (ld),
    .count_in(count_in),
    .limit   (limit),
    .en      (en),
    .mode    (mode),
    .wrap    (wrap),
    .count   (count),
    .dir     (dir),
    .tc      (tc),
    .ovf     (ovf),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int    count;
    bit    dir;
    bit    tc;
    bit    ovf;
    bit    done;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Behavioural model state
  int m_count;
  bit m_dir, m_tc, m_ovf;
  bit os_running, os_finished;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_dir = 0; m_tc = 0; m_ovf = 0;
    os_running = 0; os_finished = 0;
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One clock edge of the specified behaviour, in plain integer arithmetic.
  task automatic model_edge(input bit l, input bit c, input bit e, input int m,
                            input bit w, input int ci, input int lim);
    m_tc = 0;
    if (l) begin
      m_count = ci; m_ovf = 0; m_dir = (m == 1 || m == 3);
      os_running = (m == 3); os_finished = 0;
    end else if (c) begin
      m_count = 0; m_ovf = 0; m_dir = (m == 1 || m == 3);
      os_running = 0; os_finished = 0;
    end else begin
      if (m != 3) begin
        os_running = 0; os_finished = 0;
      end
      if (e) begin
        case (m)
          0: begin
            m_dir = 0;
            if (m_count >= lim) begin
              m_count = w ? 0 : lim; m_tc = 1; m_ovf = 1;
            end else m_count = m_count + 1;
          end
          1: begin
            m_dir = 1;
            if (m_count == 0) begin
              m_count = w ? lim : 0; m_tc = 1; m_ovf = 1;
            end else if (m_count > lim) m_count = lim;
            else m_count = m_count - 1;
          end
          2: begin
            if (!m_dir) begin
              if (m_count >= lim) begin
                m_dir = 1; m_tc = 1; m_count = (lim == 0) ? 0 : lim - 1;
              end else m_count = m_count + 1;
            end else begin
              if (m_count == 0) begin
                m_dir = 0; m_tc = 1; m_count = (lim == 0) ? 0 : 1;
              end else m_count = min2(m_count - 1, lim);
            end
          end
          default: begin
            m_dir = 1;
            if (os_running) begin
              if (m_count == 0) begin
                os_running = 0; os_finished = 1; m_tc = 1;
              end else m_count = m_count - 1;
            end
          end
        endcase
      end
    end
    m_count = m_count % (MAXV + 1);
  endtask

  task automatic push_expected(input string tag);
    exp_t x;
    x.count = m_count; x.dir = m_dir; x.tc = m_tc; x.ovf = m_ovf;
    x.done = os_finished; x.tag = tag;
    exp_q.push_back(x);
  endtask

  // Called at negedge+1: drive inputs for the next posedge, predict, advance.
  task automatic cycle(input bit l, input bit c, input bit e, input int m,
                       input bit w, input int ci, input int lim, input string tag);
    ld = l; clear = c; en = e; mode = 2'(m); wrap = w;
    count_in = 8'(ci); limit = 8'(lim);
    model_edge(l, c, e, m, w, ci, lim);
    push_expected(tag);
    @(negedge clock); #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".count"}, int'(count), 0);
    check({tag, ".dir"},   int'(dir),   0);
    check({tag, ".tc"},    int'(tc),    0);
    check({tag, ".ovf"},   int'(ovf),   0);
    check({tag, ".done"},  int'(done),  0);
  endtask

  // Reset pulsed between clock edges; outputs must clear without an edge.
  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    push_expected(tag);
    @(negedge clock); #1;
    reset_n = 1'b1;
  endtask

  // Monitor: every falling edge compares the DUT against the oldest prediction.
  initial begin
    exp_t x;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check({x.tag, ".count"}, int'(count), x.count);
        check({x.tag, ".dir"},   int'(dir),   int'(x.dir));
        check({x.tag, ".tc"},    int'(tc),    int'(x.tc));
        check({x.tag, ".ovf"},   int'(ovf),   int'(x.ovf));
        check({x.tag, ".done"},  int'(done),  int'(x.done));
      end
    end
  end

  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int r_mode, r_lim;
    bit l, c, e, w;
    int ci;
    reset_n = 1'b0; clear = 0; ld = 0; en = 0; mode = 0; wrap = 0;
    count_in = '0; limit = '0;
    model_reset();
    @(negedge clock); #1;
    check_zero("reset");
    reset_n = 1'b1;

    // Up count with wrap at limit 5
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0, 1, 0, 5, "up_wrap");
    // Down count saturating at zero
    cycle(1, 0, 0, 1, 0, 2, 5, "down_ld");
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 0, 0, 5, "down_sat");
    // Down count wrapping to limit
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, 1, 1, 0, 4, "down_wrap");
    // Ping-pong between 0 and 3
    cycle(0, 1, 0, 2, 0, 0, 3, "pp_clr");
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, 2, 1, 0, 3, "pingpong");
    // One-shot from 3, then restart from 2
    cycle(1, 0, 0, 3, 0, 3, 9, "os_ld");
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 3, 0, 0, 9, "os_run");
    cycle(1, 0, 1, 3, 0, 2, 9, "os_reld");
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 3, 0, 0, 9, "os_run2");
    // ld beats clear; count above limit saturates/wraps; then clear
    cycle(1, 1, 1, 0, 0, 8'hAA, 5, "ld_clr");
    cycle(0, 0, 1, 0, 0, 0, 5, "up_sat");
    cycle(0, 0, 1, 0, 0, 0, 5, "up_sat2");
    cycle(0, 1, 1, 0, 0, 0, 5, "clear");
    // Async reset mid one-shot RUN, then enabled one-shot must stay idle
    cycle(1, 0, 0, 3, 0, 3, 9, "os_ld2");
    cycle(0, 0, 1, 3, 0, 0, 9, "os_run3");
    async_reset("rst_mid");
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, 3, 0, 0, 9, "os_idle");
    // Limit 0 corner in ping-pong and up modes
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 2, 0, 0, 0, "pp_lim0");
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, 0, 0, 0, "up_lim0");

    // Randomized phase
    r_mode = 0; r_lim = 5;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rand_rst");
        continue;
      end
      if ($urandom_range(0, 7) == 0) r_mode = $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 5))
          0: r_lim = 0;
          1: r_lim = 1;
          2: r_lim = MAXV;
          3: r_lim = $urandom_range(0, MAXV);
          default: r_lim = $urandom_range(2, 9);
        endcase
      end
      l  = ($urandom_range(0, 9) == 0);
      c  = ($urandom_range(0, 24) == 0);
      e  = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1);
      ci = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MAXV) : $urandom_range(0, 9);
      cycle(l, c, e, r_mode, w, ci, r_lim, "rand");
    end

    @(negedge clock); #1;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
